tour_cmd_arbiter: RTL and testbench

//  Owns the single command input of cmd_proc and shares it between two requesters:
//   - the remote UART path (UART_wrapper);
//   - the tour move path (TourCmd).

---
 rtl/tour_pkg.sv | 26 ++
 rtl/sol_timer.sv | 36 +++
 rtl/tour_cmd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_tour_cmd_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared opcodes, response bytes and arbiter state encoding for the
// KnightsTour command arbiter.
package tour_pkg;

    localparam logic [3:0] OP_CAL      = 4'h2;
    localparam logic [3:0] OP_MOVE     = 4'h4;
    localparam logic [3:0] OP_MOVE_FAN = 4'h5;
    localparam logic [3:0] OP_TOUR     = 4'h6;
    localparam logic [3:0] OP_ABORT    = 4'hF;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RMT_BUSY,
        ST_WAIT_SOL,
        ST_TOUR_ISSUE,
        ST_TOUR_BUSY
    } arb_state_t;

    function automatic logic [3:0] cmd_opcode(input logic [15:0] c);
        return c[15:12];
    endfunction

endpackage

// File: rtl/sol_timer.sv
// Solution-wait timer: cleared on entry to the wait, counts while enabled
// and parks at all-ones so expiry cannot wrap.
module sol_timer #(
    parameter int FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (FAST_SIM != 0) ? 16 : 24;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = &cnt_q;

endmodule

// File: rtl/tour_cmd_arbiter.sv
// Shares the cmd_proc command input between the remote UART path and the
// tour move path, sequencing a remote start-tour through to its final ack.
module tour_cmd_arbiter
    import tour_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] rmt_cmd,
    input  logic        rmt_cmd_rdy,
    output logic        rmt_clr,
    input  logic [15:0] tour_cmd,
    input  logic        tour_cmd_rdy,
    output logic        tour_clr,
    input  logic        tour_go,
    input  logic        tour_done,
    input  logic        proc_send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_resp_rdy,
    output logic        tour_active,
    output logic        abort_tour
);

    arb_state_t  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic [7:0]  resp_q, resp_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        rmt_clr_q, rmt_clr_d;
    logic        tour_clr_q, tour_clr_d;
    logic        send_resp_q, send_resp_d;
    logic        tour_resp_rdy_q, tour_resp_rdy_d;
    logic        tour_active_q, tour_active_d;
    logic        abort_q, abort_d;
    logic        tmr_clr, tmr_expired;
    logic        rmt_new, rmt_abort;

    sol_timer #(.FAST_SIM(FAST_SIM)) u_sol_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (state_q == ST_WAIT_SOL),
        .expired (tmr_expired)
    );

    // A requester still sees its rdy high during the clr cycle; do not re-accept it.
    assign rmt_new   = rmt_cmd_rdy && !rmt_clr_q;
    assign rmt_abort = rmt_new && (cmd_opcode(rmt_cmd) == OP_ABORT);

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        resp_d          = resp_q;
        tour_active_d   = tour_active_q;
        cmd_rdy_d       = 1'b0;
        rmt_clr_d       = 1'b0;
        tour_clr_d      = 1'b0;
        send_resp_d     = 1'b0;
        tour_resp_rdy_d = 1'b0;
        abort_d         = 1'b0;
        tmr_clr         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rmt_new) begin
                    cmd_d     = rmt_cmd;
                    cmd_rdy_d = 1'b1;
                    rmt_clr_d = 1'b1;
                    if (cmd_opcode(rmt_cmd) == OP_TOUR) begin
                        state_d = ST_WAIT_SOL;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = ST_RMT_BUSY;
                    end
                end
            end
            ST_RMT_BUSY: begin
                if (proc_send_resp) begin
                    send_resp_d = 1'b1;
                    resp_d      = RESP_ACK;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_SOL: begin
                if (rmt_abort) begin
                    rmt_clr_d     = 1'b1;
                    abort_d       = 1'b1;
                    send_resp_d   = 1'b1;
                    resp_d        = RESP_NAK;
                    tour_active_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (tour_go) begin
                    tour_active_d = 1'b1;
                    state_d       = ST_TOUR_ISSUE;
                end else if (tmr_expired) begin
                    send_resp_d = 1'b1;
                    resp_d      = RESP_NAK;
                    state_d     = ST_IDLE;
                end
            end
            ST_TOUR_ISSUE, ST_TOUR_BUSY: begin
                if (rmt_abort) begin
                    rmt_clr_d     = 1'b1;
                    abort_d       = 1'b1;
                    send_resp_d   = 1'b1;
                    resp_d        = RESP_NAK;
                    tour_active_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (tour_done) begin
                    // A move finishing in the same cycle still gets its completion pulse.
                    tour_resp_rdy_d = (state_q == ST_TOUR_BUSY) && proc_send_resp;
                    send_resp_d     = 1'b1;
                    resp_d          = RESP_ACK;
                    tour_active_d   = 1'b0;
                    state_d         = ST_IDLE;
                end else if (state_q == ST_TOUR_BUSY) begin
                    if (proc_send_resp) begin
                        tour_resp_rdy_d = 1'b1;
                        state_d         = ST_TOUR_ISSUE;
                    end
                end else if (tour_cmd_rdy && !tour_clr_q) begin
                    cmd_d      = tour_cmd;
                    cmd_rdy_d  = 1'b1;
                    tour_clr_d = 1'b1;
                    state_d    = ST_TOUR_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cmd_q           <= 16'h0000;
            resp_q          <= 8'h00;
            cmd_rdy_q       <= 1'b0;
            rmt_clr_q       <= 1'b0;
            tour_clr_q      <= 1'b0;
            send_resp_q     <= 1'b0;
            tour_resp_rdy_q <= 1'b0;
            tour_active_q   <= 1'b0;
            abort_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            resp_q          <= resp_d;
            cmd_rdy_q       <= cmd_rdy_d;
            rmt_clr_q       <= rmt_clr_d;
            tour_clr_q      <= tour_clr_d;
            send_resp_q     <= send_resp_d;
            tour_resp_rdy_q <= tour_resp_rdy_d;
            tour_active_q   <= tour_active_d;
            abort_q         <= abort_d;
        end
    end

    assign cmd           = cmd_q;
    assign cmd_rdy       = cmd_rdy_q;
    assign rmt_clr       = rmt_clr_q;
    assign tour_clr      = tour_clr_q;
    assign send_resp     = send_resp_q;
    assign resp          = resp_q;
    assign tour_resp_rdy = tour_resp_rdy_q;
    assign tour_active   = tour_active_q;
    assign abort_tour    = abort_q;

endmodule

// File: tb/tb_tour_cmd_arbiter.sv
// Bench for tour_cmd_arbiter: behavioural cmd_proc / TourCmd requesters
// and per-scenario expected transaction lists.
module tb_tour_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rmt_cmd = 16'h0;
    logic        rmt_cmd_rdy = 1'b0;
    logic [15:0] tour_cmd = 16'h0;
    logic        tour_cmd_rdy = 1'b0;
    logic        tour_go = 1'b0;
    logic        tour_done = 1'b0;
    logic        proc_send_resp = 1'b0;
    logic        rmt_clr, tour_clr, cmd_rdy, send_resp, tour_resp_rdy, tour_active, abort_tour;
    logic [15:0] cmd;
    logic [7:0]  resp;

    tour_cmd_arbiter #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rmt_cmd(rmt_cmd), .rmt_cmd_rdy(rmt_cmd_rdy), .rmt_clr(rmt_clr),
        .tour_cmd(tour_cmd), .tour_cmd_rdy(tour_cmd_rdy), .tour_clr(tour_clr),
        .tour_go(tour_go), .tour_done(tour_done), .proc_send_resp(proc_send_resp),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tour_resp_rdy(tour_resp_rdy), .tour_active(tour_active), .abort_tour(abort_tour)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed transactions
    logic [15:0] cmd_log[$];
    logic [7:0]  resp_log[$];
    int          resp_cycs[$];
    int          clr_cycs[$];
    int cyc = 0, n_rclr = 0, n_tclr = 0, n_trr = 0, n_abort = 0;
    int wide = 0, dbl_issue = 0, trr_lat_bad = 0;
    int psr_cyc = 0, resp_lat = 0, cmd_cyc0 = -1, rdy_cyc = 0;
    logic p_cmd_rdy = 0, p_send = 0, p_rclr = 0, p_tclr = 0, p_trr = 0, p_abort = 0;

    // Expected transactions
    logic [15:0] exp_cmd[$];
    logic [15:0] tour_exp[$];
    logic [7:0]  exp_resp[$];
    int exp_trr, exp_abort, exp_rclr, exp_tclr;

    // Requester models
    int proc_cnt = 0;
    bit proc_hold = 0;
    int tc_left = 0;
    bit tc_wait = 0;
    bit dwl = 0;

    task automatic clear_logs();
        cmd_log.delete(); resp_log.delete(); resp_cycs.delete(); clr_cycs.delete();
        exp_cmd.delete(); tour_exp.delete(); exp_resp.delete();
        n_rclr = 0; n_tclr = 0; n_trr = 0; n_abort = 0; cmd_cyc0 = -1;
        tc_left = 0; tc_wait = 0; dwl = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cmd_rdy) begin
            cmd_log.push_back(cmd);
            if (cmd_log.size() == 1) cmd_cyc0 = cyc;
            if (proc_cnt > 0) dbl_issue++;
            proc_cnt = $urandom_range(1, 4);
        end
        if (send_resp) begin
            resp_log.push_back(resp);
            resp_cycs.push_back(cyc);
            resp_lat = cyc - psr_cyc;
        end
        if (rmt_clr) begin n_rclr++; clr_cycs.push_back(cyc); rmt_cmd_rdy = 1'b0; end
        if (tour_clr) begin n_tclr++; tour_cmd_rdy = 1'b0; tc_wait = 1'b1; end
        if (abort_tour) n_abort++;
        wide += int'(cmd_rdy && p_cmd_rdy) + int'(send_resp && p_send) + int'(rmt_clr && p_rclr)
              + int'(tour_clr && p_tclr) + int'(tour_resp_rdy && p_trr) + int'(abort_tour && p_abort);
        p_cmd_rdy = cmd_rdy; p_send = send_resp; p_rclr = rmt_clr;
        p_tclr = tour_clr; p_trr = tour_resp_rdy; p_abort = abort_tour;
        proc_send_resp = 1'b0; tour_go = 1'b0; tour_done = 1'b0;
        if (tour_resp_rdy) begin
            n_trr++;
            if (cyc - psr_cyc != 1) trr_lat_bad++;
            tc_wait = 1'b0;
            if (tc_left > 0) begin
                tc_left--;
                if (tc_left == 0) tour_done = 1'b1;
            end
        end
        if (proc_cnt > 0 && !proc_hold) begin
            proc_cnt--;
            if (proc_cnt == 0) begin
                proc_send_resp = 1'b1;
                psr_cyc = cyc;
                if (dwl && tc_wait && tc_left == 1) begin
                    tour_done = 1'b1;
                    tc_left = 0;
                end
            end
        end
        if (tour_active && !tc_wait && !tour_cmd_rdy && tc_left > 0) begin
            tour_cmd = 16'($urandom());
            tour_exp.push_back(tour_cmd);
            tour_cmd_rdy = 1'b1;
        end
    endtask

    task automatic drain();
        repeat (12) step();
    endtask

    task automatic run_until_resps(input int n, input int budget);
        int k = 0;
        while (resp_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check("resp_arrived", 32'(resp_log.size()), 32'(n));
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_ncmd"}, 32'(cmd_log.size()), 32'(exp_cmd.size()));
        foreach (exp_cmd[i])
            if (i < cmd_log.size()) check({tag, "_cmd"}, 32'(cmd_log[i]), 32'(exp_cmd[i]));
        check({tag, "_nresp"}, 32'(resp_log.size()), 32'(exp_resp.size()));
        foreach (exp_resp[i])
            if (i < resp_log.size()) check({tag, "_resp"}, 32'(resp_log[i]), 32'(exp_resp[i]));
        check({tag, "_trr"}, 32'(n_trr), 32'(exp_trr));
        check({tag, "_abort"}, 32'(n_abort), 32'(exp_abort));
        check({tag, "_rmt_clr"}, 32'(n_rclr), 32'(exp_rclr));
        check({tag, "_tour_clr"}, 32'(n_tclr), 32'(exp_tclr));
        check({tag, "_active"}, 32'(tour_active), 32'd0);
        check({tag, "_pulse_w"}, 32'(wide), 32'd0);
        check({tag, "_dbl_issue"}, 32'(dbl_issue), 32'd0);
        check({tag, "_trr_lat"}, 32'(trr_lat_bad), 32'd0);
    endtask

    task automatic normal_rmt(input logic [15:0] v);
        clear_logs();
        rmt_cmd = v; rmt_cmd_rdy = 1'b1; rdy_cyc = cyc;
        exp_cmd.push_back(v); exp_resp.push_back(8'hA5);
        exp_trr = 0; exp_abort = 0; exp_rclr = 1; exp_tclr = 0;
        run_until_resps(1, 50);
        check("rmt_cmd_lat", 32'(cmd_cyc0 - rdy_cyc), 32'd1);
        check("rmt_resp_lat", 32'(resp_lat), 32'd1);
        drain();
        compare_run("rmt");
    endtask

    // mode: 0 plain, 1 remote cmd pending mid-tour, 2 abort in TOUR_BUSY,
    // 3 abort while waiting for solution, 4 tour_done with last move's response
    task automatic tour_scn(input logic [15:0] op, input int len, input int mode);
        int k;
        int kk;
        logic [15:0] pend;
        clear_logs();
        dwl = (mode == 4);
        exp_cmd.push_back(op);
        rmt_cmd = op; rmt_cmd_rdy = 1'b1; rdy_cyc = cyc;
        k = 0;
        do begin step(); k++; end while ((proc_cnt > 0 || cmd_log.size() == 0) && k < 50);
        repeat ($urandom_range(0, 4)) step();
        check("tour_cmd_lat", 32'(cmd_cyc0 - rdy_cyc), 32'd1);
        check("active_before_go", 32'(tour_active), 32'd0);
        if (mode == 3) begin
            rmt_cmd = {4'hF, 12'($urandom())}; rmt_cmd_rdy = 1'b1;
            run_until_resps(1, 20);
            drain();
            exp_resp.push_back(8'h5A);
            exp_trr = 0; exp_abort = 1; exp_rclr = 2; exp_tclr = 0;
        end else begin
            tc_left = len;
            tour_go = 1'b1;
            if (mode == 2) begin
                kk = $urandom_range(0, len - 1);
                k = 0;
                while (cmd_log.size() < kk + 2 && k < 200) begin step(); k++; end
                check("abort_setup", 32'(cmd_log.size()), 32'(kk + 2));
                proc_hold = 1'b1;
                rmt_cmd = {4'hF, 12'($urandom())}; rmt_cmd_rdy = 1'b1;
                run_until_resps(1, 20);
                check("abort_active", 32'(tour_active), 32'd0);
                proc_hold = 1'b0;
                drain();
                foreach (tour_exp[i]) exp_cmd.push_back(tour_exp[i]);
                exp_resp.push_back(8'h5A);
                exp_trr = kk; exp_abort = 1; exp_rclr = 2; exp_tclr = kk + 1;
            end else begin
                pend = {4'h4, 12'($urandom())};
                if (mode == 1) begin
                    step(); step();
                    rmt_cmd = pend; rmt_cmd_rdy = 1'b1;
                end
                run_until_resps((mode == 1) ? 2 : 1, 400);
                drain();
                foreach (tour_exp[i]) exp_cmd.push_back(tour_exp[i]);
                exp_resp.push_back(8'hA5);
                if (mode == 1) begin
                    exp_cmd.push_back(pend);
                    exp_resp.push_back(8'hA5);
                    if (clr_cycs.size() > 1 && resp_cycs.size() > 0)
                        check("pend_after_ack", 32'(clr_cycs[1] > resp_cycs[0]), 32'd1);
                end
                exp_trr = len; exp_abort = 0; exp_rclr = (mode == 1) ? 2 : 1; exp_tclr = len;
            end
        end
        compare_run("tour");
    endtask

    initial begin
        int opc;
        int lat;
        int k;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({cmd, cmd_rdy, rmt_clr, tour_clr, send_resp, resp,
                                 tour_resp_rdy, tour_active, abort_tour}), 32'd0);
        rst_n = 1'b1;
        step();

        normal_rmt(16'h2000);
        tour_scn(16'h6033, 3, 0);
        tour_scn(16'h6033, 3, 1);
        tour_scn(16'h6033, 3, 2);
        tour_scn(16'h6033, 2, 4);

        repeat (14) begin
            case ($urandom_range(0, 5))
                0: tour_scn({4'h6, 12'($urandom())}, $urandom_range(1, 5), 0);
                1: tour_scn({4'h6, 12'($urandom())}, $urandom_range(1, 5), 1);
                2: tour_scn({4'h6, 12'($urandom())}, $urandom_range(1, 5), 2);
                3: tour_scn({4'h6, 12'($urandom())}, $urandom_range(1, 5), 3);
                4: tour_scn({4'h6, 12'($urandom())}, $urandom_range(1, 5), 4);
                default: begin
                    opc = $urandom_range(0, 13);
                    if (opc >= 6) opc++;
                    normal_rmt({4'(opc), 12'($urandom())});
                end
            endcase
        end

        // Solution never arrives
        clear_logs();
        rmt_cmd = 16'h6033; rmt_cmd_rdy = 1'b1;
        exp_cmd.push_back(16'h6033); exp_resp.push_back(8'h5A);
        exp_trr = 0; exp_abort = 0; exp_rclr = 1; exp_tclr = 0;
        run_until_resps(1, 70000);
        lat = (resp_cycs.size() > 0) ? resp_cycs[0] - cmd_cyc0 : 0;
        check("timeout_window", 32'(lat >= 65535 && lat <= 65537), 32'd1);
        drain();
        compare_run("timeout");
        normal_rmt({4'h5, 12'($urandom())});

        // Reset in the middle of a tour move
        clear_logs();
        rmt_cmd = 16'h6033; rmt_cmd_rdy = 1'b1;
        k = 0;
        do begin step(); k++; end while ((proc_cnt > 0 || cmd_log.size() == 0) && k < 50);
        tc_left = 3;
        tour_go = 1'b1;
        k = 0;
        while (cmd_log.size() < 2 && k < 100) begin step(); k++; end
        check("rst_setup_active", 32'(tour_active), 32'd1);
        proc_hold = 1'b1;
        proc_send_resp = 1'b0; tour_done = 1'b0; tour_go = 1'b0;
        tour_cmd_rdy = 1'b0; rmt_cmd_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({cmd, cmd_rdy, rmt_clr, tour_clr, send_resp, resp,
                                   tour_resp_rdy, tour_active, abort_tour}), 32'd0);
        repeat (2) @(negedge clk);
        proc_cnt = 0; proc_hold = 1'b0; tc_left = 0; tc_wait = 1'b0;
        p_cmd_rdy = 0; p_send = 0; p_rclr = 0; p_tclr = 0; p_trr = 0; p_abort = 0;
        rst_n = 1'b1;
        step();
        normal_rmt({4'h2, 12'($urandom())});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
